// File: rtl/fpu_wb_sequencer.sv
// Issue/writeback sequencer for the FP pipe: hazard-gated issue into a
// latency slot pipeline whose head drives the FP or integer write port.
module fpu_wb_sequencer #(
  parameter int LAT_LOAD = 1,
  parameter int LAT_MULT = 2,
  parameter int LAT_CVRT = 2,
  parameter int LAT_ADSB = 3,
  parameter int MAX_LAT  = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       issue_valid,
  input  logic       is_load,
  input  logic       is_adsb,
  input  logic       is_mult,
  input  logic       is_cvrt,
  input  logic       is_ftoi,
  input  logic       reg_write,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       issue_ready,
  output logic       illegal_op,
  output logic       fpr_we,
  output logic       irf_we,
  output logic [4:0] wb_waddr,
  output logic [1:0] wb_sel,
  output logic       busy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] sel;
    logic       to_int;
  } slot_t;

  slot_t       slot_q [1:MAX_LAT];
  slot_t       slot_d [1:MAX_LAT];
  logic [31:0] pend_q, pend_d;
  logic        illegal_q, illegal_d;

  logic        has_class, collide, accept;
  int          lat;
  logic [1:0]  sel;
  slot_t       entry;

  always_comb begin
    has_class = is_load | is_adsb | is_mult | is_cvrt;
    lat = 0;
    sel = 2'd0;
    if (is_load) begin
      lat = LAT_LOAD; sel = 2'd0;
    end else if (is_adsb) begin
      lat = LAT_ADSB; sel = 2'd1;
    end else if (is_mult) begin
      lat = LAT_MULT; sel = 2'd2;
    end else if (is_cvrt) begin
      lat = LAT_CVRT; sel = 2'd3;
    end

    // slot[L+1] shifts into slot[L] at the same edge the new op would land there
    collide = 1'b0;
    for (int k = 2; k <= MAX_LAT; k++)
      if (has_class && lat == k - 1 && slot_q[k].valid) collide = 1'b1;

    issue_ready = ~(collide
                    | (use_rs1   & pend_q[rs1])
                    | (use_rs2   & pend_q[rs2])
                    | (reg_write & pend_q[rd]));
    accept = issue_valid & issue_ready;

    entry = '0;
    if (reg_write | is_ftoi) begin
      entry.valid  = 1'b1;
      entry.rd     = rd;
      entry.sel    = sel;
      entry.to_int = is_ftoi;
    end
  end

  always_comb begin
    for (int k = 1; k < MAX_LAT; k++) slot_d[k] = slot_q[k+1];
    slot_d[MAX_LAT] = '0;
    for (int k = 1; k <= MAX_LAT; k++)
      if (accept && has_class && lat == k) slot_d[k] = entry;

    // clear first so a same-edge set on the same index wins
    pend_d = pend_q;
    if (slot_q[1].valid && !slot_q[1].to_int) pend_d[slot_q[1].rd] = 1'b0;
    if (accept && has_class && reg_write && !is_ftoi) pend_d[rd] = 1'b1;

    illegal_d = accept & ~has_class;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= MAX_LAT; k++) slot_q[k] <= '0;
      pend_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      for (int k = 1; k <= MAX_LAT; k++) slot_q[k] <= slot_d[k];
      pend_q    <= pend_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    fpr_we     = slot_q[1].valid & ~slot_q[1].to_int;
    irf_we     = slot_q[1].valid &  slot_q[1].to_int;
    wb_waddr   = slot_q[1].rd;
    wb_sel     = slot_q[1].sel;
    illegal_op = illegal_q;
    busy       = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) busy = busy | slot_q[k].valid;
  end

endmodule

// File: tb/tb_fpu_wb_sequencer.sv
// Random + directed bench; reference model schedules writes by absolute edge number.
module tb_fpu_wb_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       issue_valid, is_load, is_adsb, is_mult, is_cvrt, is_ftoi;
  logic       reg_write, use_rs1, use_rs2;
  logic [4:0] rs1, rs2, rd;
  logic       issue_ready, illegal_op, fpr_we, irf_we, busy;
  logic [4:0] wb_waddr;
  logic [1:0] wb_sel;

  always #5 clk = ~clk;

  fpu_wb_sequencer dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid),
    .is_load(is_load), .is_adsb(is_adsb), .is_mult(is_mult), .is_cvrt(is_cvrt),
    .is_ftoi(is_ftoi), .reg_write(reg_write), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rs1(rs1), .rs2(rs2), .rd(rd), .issue_ready(issue_ready), .illegal_op(illegal_op),
    .fpr_we(fpr_we), .irf_we(irf_we), .wb_waddr(wb_waddr), .wb_sel(wb_sel), .busy(busy)
  );

  // cls: 0 load, 1 adsb, 2 mult, 3 cvrt, 4 none
  typedef struct {
    bit       v;
    int       cls;
    bit [2:0] extra;
    bit       ftoi, rw, u1, u2;
    bit [4:0] rs1, rs2, rd;
  } op_t;

  typedef struct {
    bit [4:0] rd;
    bit [1:0] sel;
    bit       ti;
  } wb_t;

  int  checks = 0, fails = 0;
  int  n = 0;              // number of the next rising edge
  wb_t sched [int];        // edge number -> write performed at that edge
  int  pend_edge [32];     // edge of outstanding FP write per register
  bit  ill_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int cls);
    case (cls)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 2;
    endcase
  endfunction

  function automatic bit pend(input bit [4:0] r);
    return pend_edge[r] >= n;
  endfunction

  function automatic bit model_ready(input op_t op);
    bit r = 1'b1;
    if (op.cls < 4 && lat_of(op.cls) < 3 && sched.exists(n + lat_of(op.cls))) r = 1'b0;
    if (op.u1 && pend(op.rs1)) r = 1'b0;
    if (op.u2 && pend(op.rs2)) r = 1'b0;
    if (op.rw && pend(op.rd))  r = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    sched.delete();
    foreach (pend_edge[i]) pend_edge[i] = -1;
    ill_m = 1'b0;
  endtask

  task automatic drive(input op_t op);
    issue_valid = op.v;
    is_load = (op.cls == 0);
    is_adsb = (op.cls == 1) | (op.cls < 1 && op.extra[0]);
    is_mult = (op.cls == 2) | (op.cls < 2 && op.extra[1]);
    is_cvrt = (op.cls == 3) | (op.cls < 3 && op.extra[2]);
    is_ftoi = op.ftoi; reg_write = op.rw; use_rs1 = op.u1; use_rs2 = op.u2;
    rs1 = op.rs1; rs2 = op.rs2; rd = op.rd;
  endtask

  task automatic check_outputs(input string tag, input bit exp_ready);
    bit has = sched.exists(n);
    bit bz  = sched.exists(n) | sched.exists(n + 1) | sched.exists(n + 2);
    wb_t w;
    if (has) w = sched[n];
    else begin w.rd = 0; w.sel = 0; w.ti = 0; end
    chk({tag, ".ready"},   issue_ready, exp_ready);
    chk({tag, ".fpr_we"},  fpr_we, has & ~w.ti);
    chk({tag, ".irf_we"},  irf_we, has & w.ti);
    chk({tag, ".waddr"},   wb_waddr, has ? w.rd : 5'd0);
    chk({tag, ".sel"},     wb_sel, has ? w.sel : 2'd0);
    chk({tag, ".busy"},    busy, bz);
    chk({tag, ".illegal"}, illegal_op, ill_m);
  endtask

  // one clock: drive, check mid-cycle, advance model at the edge
  task automatic step(input string tag, input op_t op, output bit acc);
    bit r;
    drive(op);
    @(negedge clk);
    r = model_ready(op);
    check_outputs(tag, r);
    @(posedge clk);
    acc = op.v & r;
    if (sched.exists(n)) sched.delete(n);
    ill_m = acc && op.cls == 4;
    if (acc && op.cls < 4 && (op.rw || op.ftoi)) begin
      wb_t w;
      w.rd = op.rd; w.sel = 2'(op.cls == 0 ? 0 : op.cls == 1 ? 1 : op.cls == 2 ? 2 : 3);
      w.ti = op.ftoi;
      sched[n + lat_of(op.cls)] = w;
      if (op.rw && !op.ftoi) pend_edge[op.rd] = n + lat_of(op.cls);
    end
    n++;
    #1;
  endtask

  function automatic op_t mk(input int cls, input bit [4:0] rd_, input bit u1, input bit [4:0] r1,
                             input bit u2, input bit [4:0] r2, input bit rw, input bit ti);
    op_t o;
    o.v = 1'b1; o.cls = cls; o.extra = 3'b000; o.ftoi = ti; o.rw = rw;
    o.u1 = u1; o.u2 = u2; o.rs1 = r1; o.rs2 = r2; o.rd = rd_;
    return o;
  endfunction

  function automatic op_t nop();
    op_t o = mk(4, 0, 0, 0, 0, 0, 0, 0);
    o.v = 1'b0;
    return o;
  endfunction

  task automatic idle(input int cyc);
    bit a;
    for (int i = 0; i < cyc; i++) step("idle", nop(), a);
  endtask

  task automatic raw_case(input string tag, input op_t dep);
    bit a;
    step({tag, ".mul"}, mk(2, 3, 0, 0, 0, 0, 1, 0), a);
    chk({tag, ".mul_acc"}, a, 1'b1);
    step({tag, ".e1"}, dep, a); chk({tag, ".stall_e1"}, a, 1'b0);
    step({tag, ".e2"}, dep, a); chk({tag, ".stall_e2"}, a, 1'b0);
    step({tag, ".e3"}, dep, a); chk({tag, ".acc_e3"},   a, 1'b1);
    idle(4);
  endtask

  initial begin
    bit a;
    op_t o;
    model_reset();
    drive(nop());
    rstn = 1'b0;
    #3;
    check_outputs("reset_async", 1'b1);
    @(negedge clk);
    check_outputs("reset_hold", 1'b1);
    rstn = 1'b1;
    @(posedge clk); #1;
    idle(3);

    // fadd rd=5 written at E3
    step("fadd", mk(1, 5, 0, 0, 0, 0, 1, 0), a);
    chk("fadd.acc", a, 1'b1);
    step("fadd.e1", nop(), a);
    step("fadd.e2", nop(), a);
    chk("fadd.we_before_e3", fpr_we, 1'b1);
    chk("fadd.waddr_before_e3", wb_waddr, 5'd5);
    step("fadd.e3", nop(), a);
    chk("fadd.busy_after_e3", busy, 1'b0);
    idle(2);

    // port collision
    step("col.add", mk(1, 1, 0, 0, 0, 0, 1, 0), a);
    chk("col.add_acc", a, 1'b1);
    step("col.mul1", mk(2, 2, 0, 0, 0, 0, 1, 0), a);
    chk("col.mul_stall", a, 1'b0);
    step("col.mul2", mk(2, 2, 0, 0, 0, 0, 1, 0), a);
    chk("col.mul_acc", a, 1'b1);
    idle(4);

    raw_case("raw1", mk(1, 9, 1, 3, 0, 0, 1, 0));
    raw_case("raw2", mk(1, 9, 0, 0, 1, 3, 1, 0));
    raw_case("waw",  mk(1, 3, 0, 0, 0, 0, 1, 0));

    // fcvt.w.s rd=7: integer port, no pending bit
    step("ftoi", mk(3, 7, 0, 0, 0, 0, 0, 1), a);
    chk("ftoi.acc", a, 1'b1);
    step("ftoi.e1", mk(1, 8, 1, 7, 0, 0, 1, 0), a);
    chk("ftoi.no_pend", a, 1'b1);
    idle(4);

    // illegal op: no class flag
    o = mk(4, 4, 0, 0, 0, 0, 0, 0);
    step("ill", o, a);
    chk("ill.acc", a, 1'b1);
    step("ill.e1", nop(), a);
    idle(2);

    // async reset mid-flight
    step("ar.add", mk(1, 10, 0, 0, 0, 0, 1, 0), a);
    step("ar.mul", mk(2, 11, 0, 0, 0, 0, 1, 0), a);
    drive(nop());
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("ar.during", 1'b1);
    #1 rstn = 1'b1;
    idle(5);

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      o.v     = ($urandom_range(0, 3) != 0);
      o.cls   = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3));
      o.extra = 3'($urandom);
      o.ftoi  = (o.cls == 3) && ($urandom_range(0, 2) == 0);
      o.rw    = (o.cls != 4) && ($urandom_range(0, 4) != 0);
      o.u1    = 1'($urandom);
      o.u2    = 1'($urandom);
      o.rs1   = 5'($urandom_range(0, 5));
      o.rs2   = 5'($urandom_range(0, 5));
      o.rd    = 5'($urandom_range(0, 5));
      step("rnd", o, a);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
